spi_ram_arbiter: RTL and testbench

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - Shares one single-port RAM between an SPI command stream and a host port
//
// Purpose:
//   SPI command words (spi_rx_data[9:8]) set the write/read pointers or queue
//   one RAM write/read in a single-entry pending buffer. The host port issues
//   req/gnt transactions. An IDLE/ACC/RESP FSM grants one requester at a time
//   with round-robin on ties. Read data is returned on host_rdata/host_rvalid
//   or loaded into spi_tx_data with an 8-cycle spi_tx_valid shift window.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   spi_rx_data, spi_rx_valid     SPI command word and one-cycle strobe
//   spi_tx_data, spi_tx_valid     SPI read data and shift enable
//   host_req/we/addr/wdata        host request, held until host_gnt
//   host_gnt                      combinational grant in the winning IDLE cycle
//   host_rdata, host_rvalid       host read data, one-cycle valid
//   ram_en/we/addr/wdata/rdata    RAM port, rdata valid the cycle after ram_en
//   spi_overrun                   one-cycle pulse when an SPI command is dropped
module spi_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        spi_rx_data,
    input  logic              spi_rx_valid,
    output logic [7:0]        spi_tx_data,
    output logic              spi_tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              spi_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                pend_valid_q, pend_valid_d;
    logic                pend_we_q, pend_we_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_wdata_q, pend_wdata_d;
    logic                last_host_q, last_host_d;
    logic                acc_we_q, acc_we_d;
    logic                acc_host_q, acc_host_d;
    logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [3:0]          tx_cnt_q, tx_cnt_d;
    logic                overrun_q, overrun_d;

    logic idle;
    logic host_win;
    logic spi_win;

    // On a tie the requester that did not win last time takes the RAM.
    assign idle     = (state_q == ST_IDLE);
    assign host_win = idle && host_req && (!pend_valid_q || !last_host_q);
    assign spi_win  = idle && pend_valid_q && (!host_req || last_host_q);

    assign host_gnt     = rst_n && host_win;
    assign ram_en       = (state_q == ST_ACC);
    assign ram_we       = ram_en && acc_we_q;
    assign ram_addr     = acc_addr_q;
    assign ram_wdata    = acc_wdata_q;
    assign host_rdata   = host_rdata_q;
    assign host_rvalid  = host_rvalid_q;
    assign spi_tx_data  = tx_data_q;
    assign spi_tx_valid = (tx_cnt_q != 4'd0);
    assign spi_overrun  = overrun_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pend_valid_d  = pend_valid_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        last_host_d   = last_host_q;
        acc_we_d      = acc_we_q;
        acc_host_d    = acc_host_q;
        acc_addr_d    = acc_addr_q;
        acc_wdata_d   = acc_wdata_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_cnt_d      = (tx_cnt_q != 4'd0) ? tx_cnt_q - 4'd1 : 4'd0;
        overrun_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host_win) begin
                    acc_we_d    = host_we;
                    acc_host_d  = 1'b1;
                    acc_addr_d  = host_addr;
                    acc_wdata_d = host_wdata;
                    last_host_d = 1'b1;
                    state_d     = ST_ACC;
                end else if (spi_win) begin
                    acc_we_d     = pend_we_q;
                    acc_host_d   = 1'b0;
                    acc_addr_d   = pend_addr_q;
                    acc_wdata_d  = pend_wdata_q;
                    last_host_d  = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = ST_ACC;
                end
            end
            ST_ACC: begin
                state_d = acc_we_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (acc_host_q) begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end else begin
                    // A fresh read restarts the shift window even mid-transfer.
                    tx_data_d = 8'(ram_rdata);
                    tx_cnt_d  = 4'd8;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (spi_rx_valid) begin
            case (spi_rx_data[9:8])
                2'b00: wr_ptr_d = spi_rx_data[ADDR_W-1:0];
                2'b10: rd_ptr_d = spi_rx_data[ADDR_W-1:0];
                default: begin
                    // The buffer slot frees up in the same cycle it is granted,
                    // so only a full, ungranted buffer drops the command.
                    if (pend_valid_q && !spi_win) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_we_d    = !spi_rx_data[9];
                        pend_addr_d  = spi_rx_data[9] ? rd_ptr_q : wr_ptr_q;
                        pend_wdata_d = DATA_W'(spi_rx_data[7:0]);
                        if (spi_rx_data[9]) begin
                            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        end else begin
                            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_wdata_q  <= '0;
            last_host_q   <= 1'b1;
            acc_we_q      <= 1'b0;
            acc_host_q    <= 1'b0;
            acc_addr_q    <= '0;
            acc_wdata_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            tx_data_q     <= '0;
            tx_cnt_q      <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pend_valid_q  <= pend_valid_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            last_host_q   <= last_host_d;
            acc_we_q      <= acc_we_d;
            acc_host_q    <= acc_host_d;
            acc_addr_q    <= acc_addr_d;
            acc_wdata_q   <= acc_wdata_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            tx_data_q     <= tx_data_d;
            tx_cnt_q      <= tx_cnt_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - Self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       spi_overrun;

    spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .spi_overrun(spi_overrun)
    );

    // RAM attached to the DUT
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: event not seen within bound at %0t", nm, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_mem [256];
    bit         seen_rst = 0;
    logic [7:0] m_wr_ptr, m_rd_ptr;
    bit         m_buf_v, m_buf_we;
    logic [7:0] m_buf_addr, m_buf_data;
    bit         m_last_host;
    int         m_busy;             // cycles left before the RAM is free again
    bit         m_acc, m_acc_we, m_acc_host;
    logic [7:0] m_acc_addr, m_acc_data;
    bit         m_resp, m_resp_host;
    logic [7:0] m_resp_data;
    bit         m_rvalid;
    logic [7:0] m_hrdata;
    int         m_tx_left;
    logic [7:0] m_tx_data;
    bit         m_ovr;
    bit         m_idle, m_hw, m_sw;
    logic [1:0] m_cmd;
    logic [7:0] m_lo;

    always @(negedge clk) begin
        #2;
        m_idle = (m_busy == 0);
        m_hw   = m_idle && host_req && (!m_buf_v || !m_last_host);
        m_sw   = m_idle && m_buf_v && (!host_req || m_last_host);
        if (seen_rst) begin
            chk("host_gnt", host_gnt, rst_n && m_hw);
            chk("ram_en", ram_en, m_acc);
            chk("ram_we", ram_we, m_acc && m_acc_we);
            if (m_acc) begin
                chk("ram_addr", ram_addr, m_acc_addr);
                if (m_acc_we) chk("ram_wdata", ram_wdata, m_acc_data);
            end
            chk("host_rvalid", host_rvalid, m_rvalid);
            chk("host_rdata", host_rdata, m_hrdata);
            chk("spi_tx_valid", spi_tx_valid, m_tx_left != 0);
            chk("spi_tx_data", spi_tx_data, m_tx_data);
            chk("spi_overrun", spi_overrun, m_ovr);
        end
        // advance the model across the coming rising edge
        if (m_acc && m_acc_we) m_mem[m_acc_addr] = m_acc_data;
        if (!rst_n) begin
            seen_rst = 1;
            m_wr_ptr = 0; m_rd_ptr = 0; m_buf_v = 0; m_last_host = 1; m_busy = 0;
            m_acc = 0; m_resp = 0; m_rvalid = 0; m_hrdata = 0;
            m_tx_left = 0; m_tx_data = 0; m_ovr = 0;
        end else begin
            m_rvalid = 0;
            if (m_tx_left != 0) m_tx_left--;
            if (m_resp) begin
                if (m_resp_host) begin
                    m_rvalid = 1; m_hrdata = m_resp_data;
                end else begin
                    m_tx_left = 8; m_tx_data = m_resp_data;
                end
            end
            m_resp      = m_acc && !m_acc_we;
            m_resp_host = m_acc_host;
            m_resp_data = m_mem[m_acc_addr];
            m_acc = 0;
            if (m_hw) begin
                m_acc = 1; m_acc_host = 1; m_acc_we = host_we;
                m_acc_addr = host_addr; m_acc_data = host_wdata;
                m_last_host = 1; m_busy = host_we ? 1 : 2;
            end else if (m_sw) begin
                m_acc = 1; m_acc_host = 0; m_acc_we = m_buf_we;
                m_acc_addr = m_buf_addr; m_acc_data = m_buf_data;
                m_last_host = 0; m_busy = m_buf_we ? 1 : 2; m_buf_v = 0;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            m_ovr = 0;
            if (spi_rx_valid) begin
                m_cmd = spi_rx_data[9:8];
                m_lo  = spi_rx_data[7:0];
                if (m_cmd == 2'd0) m_wr_ptr = m_lo;
                else if (m_cmd == 2'd2) m_rd_ptr = m_lo;
                else if (m_buf_v) m_ovr = 1;
                else begin
                    m_buf_v    = 1;
                    m_buf_we   = (m_cmd == 2'd1);
                    m_buf_addr = m_buf_we ? m_wr_ptr : m_rd_ptr;
                    m_buf_data = m_lo;
                    if (m_buf_we) m_wr_ptr++; else m_rd_ptr++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
        spi_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt();
    endtask

    task automatic spi_cmd(input logic [9:0] w);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        nxt();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; host_req = 1'b0; spi_rx_valid = 1'b0;
        nxt(); nxt();
        rst_n = 1'b1;
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d, output int waited);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; waited = -1;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (host_gnt === 1'b1) begin
                waited = i; nxt(); host_req = 1'b0; return;
            end
            nxt();
        end
        host_req = 1'b0;
        timeout("host_gnt");
    endtask

    task automatic wait_en(output logic [7:0] a, output logic w, output logic [7:0] d);
        a = 'x; w = 'x; d = 'x;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (ram_en === 1'b1) begin
                a = ram_addr; w = ram_we; d = ram_wdata; nxt(); return;
            end
            nxt();
        end
        timeout("ram_en");
    endtask

    logic [7:0] a, d;
    logic       w;
    int         wt, cnt, bad, lat, nh, ns, prev, src, rv;
    bit         found, got;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00; m_mem[i] = 8'h00;
        end
        ram_rdata = 8'h00;
        rst_n = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        nxt(); nxt();
        // grant is masked while reset is asserted
        host_req = 1'b1;
        #2 chk("gnt_in_reset", host_gnt, 1'b0);
        nxt();
        host_req = 1'b0;
        rst_n = 1'b1;
        #2;
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_host_rdata", host_rdata, 8'h00);
        chk("rst_tx_valid", spi_tx_valid, 1'b0);
        chk("rst_tx_data", spi_tx_data, 8'h00);
        chk("rst_overrun", spi_overrun, 1'b0);
        nxt();

        // SPI write 0x05<-0xA5 then read it back through the shift window
        spi_cmd(10'h005); spi_cmd(10'h1A5); spi_cmd(10'h205); spi_cmd(10'h300);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #2;
            if (spi_tx_valid === 1'b1) found = 1; else nxt();
        end
        cnt = 0; bad = 0;
        if (!found) timeout("spi_tx_valid");
        else while (spi_tx_valid === 1'b1 && cnt < 20) begin
            if (spi_tx_data !== 8'hA5) bad++;
            cnt++; nxt(); #2;
        end
        nxt();
        chk("tx_window_len", cnt, 8);
        chk("tx_unstable_cycles", bad, 0);
        chk("tx_data_hold", spi_tx_data, 8'hA5);
        spi_cmd(10'h15A); wait_en(a, w, d);
        chk("wr_ptr_06_addr", a, 8'h06); chk("wr_ptr_06_we", w, 1'b1); chk("wr_ptr_06_data", d, 8'h5A);
        spi_cmd(10'h300); wait_en(a, w, d);
        chk("rd_ptr_06_addr", a, 8'h06); chk("rd_ptr_06_we", w, 1'b0);

        // host write then read of 0x10
        idle(6);
        host_op(1'b1, 8'h10, 8'h3C, wt); chk("host_wr_wait", wt, 0);
        host_op(1'b0, 8'h10, 8'h00, wt); chk("host_rd_wait", wt, 1);
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            #2;
            if (host_rvalid === 1'b1) lat = k;
            nxt();
        end
        chk("host_rvalid_latency", lat, 3);
        chk("host_rdata", host_rdata, 8'h3C);

        // first tie after reset goes to SPI; wr_ptr wraps from 0xFF
        reset_dut();
        spi_cmd(10'h0FF); spi_cmd(10'h111);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h99;
        #2 chk("tie_gnt_G", host_gnt, 1'b0);
        nxt();
        #2;
        chk("tie_spi_en", ram_en, 1'b1); chk("tie_spi_addr", ram_addr, 8'hFF);
        chk("tie_spi_data", ram_wdata, 8'h11); chk("tie_gnt_G1", host_gnt, 1'b0);
        nxt();
        #2 chk("tie_gnt_G2", host_gnt, 1'b1);
        nxt();
        host_req = 1'b0;
        spi_cmd(10'h122); wait_en(a, w, d);
        chk("wrap_addr", a, 8'h00); chk("wrap_data", d, 8'h22);

        // continuous contention alternates grants
        idle(6); spi_cmd(10'h080);
        prev = -1; bad = 0; nh = 0; ns = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'hC0; host_wdata = 8'h5E;
        for (int i = 0; i < 24; i++) begin
            spi_rx_data = {2'b01, 8'(i)}; spi_rx_valid = 1'b1;
            #2;
            if (ram_en === 1'b1) begin
                src = (ram_addr == 8'hC0) ? 1 : 0;
                if (src == 1) nh++; else ns++;
                if (prev == src) bad++;
                prev = src;
            end
            nxt();
        end
        host_req = 1'b0;
        idle(6);
        chk("rr_alternation_breaks", bad, 0);
        chk("rr_host_grants_ge5", nh >= 5, 1'b1);
        chk("rr_spi_grants_ge5", ns >= 5, 1'b1);

        // overrun while the host read holds the RAM
        idle(4); spi_cmd(10'h040);
        host_op(1'b0, 8'h30, 8'h00, wt);
        spi_cmd(10'h1AA); spi_cmd(10'h1BB);
        #2 chk("overrun_pulse", spi_overrun, 1'b1);
        nxt();
        #2;
        chk("overrun_one_cycle", spi_overrun, 1'b0);
        chk("kept_cmd_en", ram_en, 1'b1); chk("kept_cmd_addr", ram_addr, 8'h40);
        chk("kept_cmd_data", ram_wdata, 8'hAA);
        nxt();
        spi_cmd(10'h1CC); wait_en(a, w, d);
        chk("wr_ptr_once_addr", a, 8'h41); chk("wr_ptr_once_data", d, 8'hCC);

        // reset during the ACC cycle of a host read
        idle(6);
        host_op(1'b0, 8'h10, 8'h00, wt);
        rst_n = 1'b0;
        #2 chk("acc_before_reset", ram_en, 1'b1);
        nxt();
        rst_n = 1'b1;
        #2 chk("ram_en_after_reset", ram_en, 1'b0);
        nxt();
        rv = 0;
        repeat (6) begin
            #2;
            if (host_rvalid === 1'b1) rv++;
            nxt();
        end
        chk("aborted_rvalid", rv, 0);
        spi_cmd(10'h177); wait_en(a, w, d); chk("ptr_reset_wr", a, 8'h00);
        spi_cmd(10'h300); wait_en(a, w, d); chk("ptr_reset_rd", a, 8'h00);
        idle(14);

        // randomized traffic against the model
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if (!rst_n || got) host_req = 1'b0;
            if (!host_req && rst_n && $urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 9) < 4) begin
                m_cmd = 2'($urandom_range(0, 3));
                spi_rx_data  = {m_cmd, (m_cmd[0] ? 8'($urandom) : 8'($urandom_range(0, 15)))};
                spi_rx_valid = 1'b1;
            end
            #2 got = (host_gnt === 1'b1);
            nxt();
        end
        rst_n = 1'b1; host_req = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
